// File: rtl/pipe_register.sv
// Elastic pipeline register: DEPTH valid/ready stages with bubble collapsing,
// synchronous flush and a registered occupancy count.
module pipe_register #(
    parameter int   WIDTH       = 32,
    parameter int   DEPTH       = 2,
    parameter logic RESET_VALUE = 1'b0,
    parameter int   CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    generate
        if (DEPTH < 1) begin : g_depth_check
            $error("pipe_register: DEPTH must be at least 1");
        end
    endgenerate

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] up_valid;
    logic [WIDTH-1:0] d [DEPTH];
    logic [WIDTH-1:0] up_data [DEPTH];
    logic             xfer_in;
    logic             xfer_out;

    // Each stage may advance if it or any stage downstream of it is empty, or
    // the consumer is taking the last item. Written per stage so no bit of
    // rdy feeds another bit of rdy.
    always_comb begin : ready_chain
        logic acc;
        rdy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            acc = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                acc = acc | ~v[j];
            end
            rdy[i] = acc;
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_up
            if (i == 0) begin : g_head
                assign up_valid[i] = in_valid;
                assign up_data[i]  = in_data;
            end else begin : g_body
                assign up_valid[i] = v[i-1];
                assign up_data[i]  = d[i-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= {WIDTH{RESET_VALUE}};
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v[i] <= up_valid[i];
                    if (up_valid[i]) begin
                        d[i] <= up_data[i];
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v[DEPTH-1] & ~flush;
    assign out_data  = d[DEPTH-1];

    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (xfer_in && !xfer_out) begin
            count <= count + CNT_W'(1);
        end else if (!xfer_in && xfer_out) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule
